robot_task_enabler: RTL and testbench
=====================================

# robot_task_enabler

Multi-channel successor to the single-trigger robot enable latch. Collects one-cycle CSL event pulses from up to NUM_CH sources and grants the robot to one channel at a time using round-robin order. Each grant ends on `resolved`, or on a watchdog timeout that re-queues the channel. A fixed cooldown separates consecutive grants. The block sits between the CSL detection logic and the robot motion controller.

## Interface

- NUM_CH, 4, number of event channels; legal range is 2 or more.
- TIMEOUT, 1000, maximum number of cycles `robot_enabled` stays high for one grant; legal range is 1 or more.
- TMR_W, 16, width of the watchdog timer; TIMEOUT must be at most 2^TMR_W.
- COOLDOWN, 2, number of cycles `robot_enabled` stays low between grants; legal range is 1 or more.
- CNT_W, 8, width of the served-event counter.

- clk  in  1  clock.
- reset  in  1  reset, asynchronous, active-high.
- csl_valid  in  NUM_CH  per-channel event pulse; bit c high for one cycle raises a request on channel c.
- resolved  in  1  pulse that completes the active grant.
- robot_enabled  out  1  robot enable; reset value 0.
- active_ch  out  $clog2(NUM_CH)  channel currently or most recently granted; reset value 0.
- pending  out  NUM_CH  latched outstanding requests; reset value 0.
- timeout_pulse  out  1  one-cycle flag marking a watchdog expiry; reset value 0.
- served_count  out  CNT_W  count of grants ended by `resolved`; saturates at all-ones; reset value 0.

## Operation

- Request latch: on each edge, `pending[c]` is set if `csl_valid[c]` is high.
  - `pending[c]` is cleared only when channel c is granted.
  - If a set and a clear hit the same bit in the same cycle, the set wins and the bit stays 1.
- Round-robin pointer `last_ch` resets to NUM_CH-1, so the first search starts at channel 0.
  - Search order is last_ch+1, last_ch+2, … wrapping modulo NUM_CH.
- FSM states are IDLE, ENABLED and COOLDOWN. Reset state is IDLE.
- IDLE: if `pending` is non-zero, pick the first set bit in search order as ch.
  - At the next edge: enter ENABLED, set `robot_enabled`=1, `active_ch`=ch, `last_ch`=ch, clear `pending[ch]`, and set timer=0.
  - If `pending` is zero, stay in IDLE.
- ENABLED: timer increments every cycle.
  - `resolved`=1: at the next edge enter COOLDOWN, set `robot_enabled`=0, and increment `served_count` (saturating).
  - Otherwise, if timer==TIMEOUT-1: at the next edge enter COOLDOWN, set `robot_enabled`=0, pulse `timeout_pulse` for one cycle, and set `pending[active_ch]`=1 so the channel is retried.
  - If `resolved` and the timeout condition occur in the same cycle, `resolved` wins and no timeout is flagged.
  - A `csl_valid` pulse on the active channel during ENABLED sets its pending bit, which queues a new event.
- COOLDOWN: counts COOLDOWN cycles with `robot_enabled`=0, then enters IDLE.
- `resolved` is ignored in IDLE and COOLDOWN.
- `active_ch` holds its last value outside ENABLED.
- Reset during any state: all outputs, `pending`, timer and counters return to their reset values immediately; the FSM enters IDLE.

## Timing

- A `csl_valid` pulse sampled at edge t sets `pending` visible after t.
  - With the FSM idle, `robot_enabled` rises after edge t+1, i.e. 2-cycle latency from pulse to enable.
- `resolved` sampled at edge t drops `robot_enabled` after edge t.
- The next grant can rise no earlier than COOLDOWN+1 cycles after the fall.
- Without `resolved`, `robot_enabled` is high for exactly TIMEOUT cycles.
- `timeout_pulse` is coincident with the first low cycle of `robot_enabled`.
- `served_count` and `pending` updates are visible the cycle after the causing edge.
- No combinational path from any input to any output.

## Test plan

- Single event, default parameters:
  - Reset, then pulse `csl_valid`=4'b0100 → `pending`=0100 for one cycle, then `robot_enabled`=1 with `active_ch`=2 two cycles after the pulse.
  - Pulse `resolved` → enable falls, `served_count`=1.
- Round-robin: pulse `csl_valid`=4'b1111 at once and resolve each grant → grant order is 0,1,2,3 with `served_count` ending at 4.
  - Then pulse 4'b1001 → channel 0 is granted before channel 3, because `last_ch`=3.
- Timeout with TIMEOUT=5: grant channel 1 and never resolve → enable is high for exactly 5 cycles.
  - `timeout_pulse` lasts one cycle, `pending[1]` is re-set, and channel 1 is re-granted after COOLDOWN+1 cycles.
  - `served_count` stays unchanged.
- Collisions:
  - `resolved` on the cycle where timer==TIMEOUT-1 → no `timeout_pulse`, `served_count` increments.
  - `csl_valid[c]` on the grant cycle of c → `pending[c]` stays 1.
- Mid-grant reset: assert `reset` while ENABLED with `pending`=0110 → `robot_enabled`, `pending` and `served_count` go to 0 immediately.
  - After release, the first grant goes to channel 0 only if it is requested.
- Saturation with CNT_W=2: resolve 5 grants → `served_count` stays at 3.

Source files
------------

// File: rtl/robot_task_enabler_if.sv
// Request/grant bundle between the CSL detectors, the task enabler and the
// robot motion controller.
//   csl_valid     : per-channel one-cycle event pulses (master -> slave)
//   resolved      : pulse completing the active grant (master -> slave)
//   robot_enabled : robot enable (slave -> master)
//   active_ch     : channel currently or most recently granted
//   pending       : latched outstanding requests
//   timeout_pulse : one-cycle watchdog expiry flag
//   served_count  : saturating count of grants ended by resolved
interface robot_task_enabler_if #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CNT_W  = 8
);
  localparam int unsigned CH_W = $clog2(NUM_CH);

  logic [NUM_CH-1:0] csl_valid;
  logic              resolved;
  logic              robot_enabled;
  logic [CH_W-1:0]   active_ch;
  logic [NUM_CH-1:0] pending;
  logic              timeout_pulse;
  logic [CNT_W-1:0]  served_count;

  modport master (
    output csl_valid, resolved,
    input  robot_enabled, active_ch, pending, timeout_pulse, served_count
  );

  modport slave (
    input  csl_valid, resolved,
    output robot_enabled, active_ch, pending, timeout_pulse, served_count
  );
endinterface

// File: rtl/robot_task_enabler.sv
// Round-robin robot task enabler. Latches CSL event pulses per channel and
// grants the robot to one channel at a time; a grant ends on resolved or on
// a watchdog timeout (which re-queues the channel), followed by a fixed
// cooldown before the next grant.
//   clk   : clock
//   reset : asynchronous, active-high reset
//   bus   : robot_task_enabler_if slave (all outputs registered)
module robot_task_enabler #(
  parameter int unsigned NUM_CH   = 4,
  parameter int unsigned TIMEOUT  = 1000,
  parameter int unsigned TMR_W    = 16,
  parameter int unsigned COOLDOWN = 2,
  parameter int unsigned CNT_W    = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  robot_task_enabler_if.slave  bus
);
  localparam int unsigned CH_W = $clog2(NUM_CH);
  localparam int unsigned CD_W = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
  localparam logic [CD_W-1:0]  CD_LAST  = CD_W'(COOLDOWN - 1);
  localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(NUM_CH - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ENABLED,
    ST_COOLDOWN
  } state_t;

  state_t            state_q, state_d;
  logic              en_q, en_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic [CH_W-1:0]   last_q, last_d;
  logic [NUM_CH-1:0] pend_q, pend_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic [CD_W-1:0]   cd_q, cd_d;
  logic              to_q, to_d;
  logic [CNT_W-1:0]  served_q, served_d;

  logic [NUM_CH-1:0] clr_mask;
  logic [NUM_CH-1:0] retry_mask;
  logic              pick_found;
  logic [CH_W-1:0]   pick_ch;
  logic [31:0]       srch_idx;
  logic [NUM_CH-1:0] csl_valid;
  logic              resolved;

  assign csl_valid = bus.csl_valid;
  assign resolved  = bus.resolved;

  // Round-robin search: first pending channel after last_q, wrapping.
  always_comb begin
    pick_found = 1'b0;
    pick_ch    = '0;
    srch_idx   = '0;
    for (int unsigned i = 1; i <= NUM_CH; i++) begin
      srch_idx = (32'(last_q) + i) % NUM_CH;
      if (!pick_found && pend_q[srch_idx[CH_W-1:0]]) begin
        pick_found = 1'b1;
        pick_ch    = srch_idx[CH_W-1:0];
      end
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d    = state_q;
    en_d       = en_q;
    ch_d       = ch_q;
    last_d     = last_q;
    timer_d    = timer_q;
    cd_d       = cd_q;
    to_d       = 1'b0;
    served_d   = served_q;
    clr_mask   = '0;
    retry_mask = '0;

    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          state_d           = ST_ENABLED;
          en_d              = 1'b1;
          ch_d              = pick_ch;
          last_d            = pick_ch;
          clr_mask[pick_ch] = 1'b1;
          timer_d           = '0;
        end
      end
      ST_ENABLED: begin
        timer_d = timer_q + 1'b1;
        // resolved takes priority over a coincident watchdog expiry
        if (resolved) begin
          state_d = ST_COOLDOWN;
          en_d    = 1'b0;
          cd_d    = '0;
          if (served_q != {CNT_W{1'b1}}) begin
            served_d = served_q + 1'b1;
          end
        end else if (timer_q == TMR_LAST) begin
          state_d          = ST_COOLDOWN;
          en_d             = 1'b0;
          cd_d             = '0;
          to_d             = 1'b1;
          retry_mask[ch_q] = 1'b1;
        end
      end
      ST_COOLDOWN: begin
        if (cd_q == CD_LAST) begin
          state_d = ST_IDLE;
        end else begin
          cd_d = cd_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A new pulse on the channel being granted wins over its clear.
    pend_d = (pend_q & ~clr_mask) | csl_valid | retry_mask;
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      en_q     <= 1'b0;
      ch_q     <= '0;
      last_q   <= CH_LAST;
      pend_q   <= '0;
      timer_q  <= '0;
      cd_q     <= '0;
      to_q     <= 1'b0;
      served_q <= '0;
    end else begin
      state_q  <= state_d;
      en_q     <= en_d;
      ch_q     <= ch_d;
      last_q   <= last_d;
      pend_q   <= pend_d;
      timer_q  <= timer_d;
      cd_q     <= cd_d;
      to_q     <= to_d;
      served_q <= served_d;
    end
  end

  assign bus.robot_enabled = en_q;
  assign bus.active_ch     = ch_q;
  assign bus.pending       = pend_q;
  assign bus.timeout_pulse = to_q;
  assign bus.served_count  = served_q;
endmodule

// File: tb/tb_robot_task_enabler.sv
// Self-checking bench for robot_task_enabler: directed scenarios plus a
// randomized run against a behavioural grant/queue model.
module tb_robot_task_enabler;
  localparam int unsigned NUM_CH   = 4;
  localparam int unsigned TIMEOUT  = 5;
  localparam int unsigned TMR_W    = 4;
  localparam int unsigned COOLDOWN = 2;
  localparam int unsigned CNT_W    = 2;
  localparam int unsigned CH_W     = $clog2(NUM_CH);
  localparam int          CNT_MAX  = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic reset = 1'b1;

  robot_task_enabler_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) bus ();

  robot_task_enabler #(
    .NUM_CH(NUM_CH), .TIMEOUT(TIMEOUT), .TMR_W(TMR_W),
    .COOLDOWN(COOLDOWN), .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Behavioural model: mode 0 = waiting, 1 = robot granted, 2 = resting.
  bit [NUM_CH-1:0] m_pend;
  int m_mode, m_ch, m_last, m_age, m_rest, m_served;
  bit m_en, m_to;

  function automatic void model_reset();
    m_pend = '0; m_mode = 0; m_ch = 0; m_last = NUM_CH - 1;
    m_age = 0; m_rest = 0; m_served = 0; m_en = 1'b0; m_to = 1'b0;
  endfunction

  function automatic int rr_pick(bit [NUM_CH-1:0] p, int last);
    for (int k = 1; k <= int'(NUM_CH); k++) begin
      int c = (last + k) % int'(NUM_CH);
      if (p[c]) return c;
    end
    return -1;
  endfunction

  function automatic void model_step(bit [NUM_CH-1:0] csl, bit res);
    bit [NUM_CH-1:0] np = m_pend | csl;
    int c;
    m_to = 1'b0;
    case (m_mode)
      0: begin
        c = rr_pick(m_pend, m_last);
        if (c >= 0) begin
          m_mode = 1; m_en = 1'b1; m_ch = c; m_last = c; m_age = 1;
          np[c] = csl[c];
        end
      end
      1: begin
        if (res) begin
          m_mode = 2; m_en = 1'b0; m_rest = COOLDOWN;
          if (m_served < CNT_MAX) m_served++;
        end else if (m_age == int'(TIMEOUT)) begin
          m_mode = 2; m_en = 1'b0; m_rest = COOLDOWN; m_to = 1'b1;
          np[m_ch] = 1'b1;
        end else begin
          m_age++;
        end
      end
      default: begin
        m_rest--;
        if (m_rest == 0) m_mode = 0;
      end
    endcase
    m_pend = np;
  endfunction

  task automatic tick(input bit [NUM_CH-1:0] csl, input bit res);
    bus.csl_valid = csl;
    bus.resolved  = res;
    @(posedge clk);
    model_step(csl, res);
    #1;
    bus.csl_valid = '0;
    bus.resolved  = 1'b0;
  endtask

  task automatic idle_ticks(input int n);
    repeat (n) tick('0, 1'b0);
  endtask

  task automatic do_reset();
    bus.csl_valid = '0;
    bus.resolved  = 1'b0;
    reset = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (bus.robot_enabled !== 1'b0) begin errors++; $display("FAIL reset_en: got %b expected 0", bus.robot_enabled); end
    checks++; if (bus.active_ch !== '0) begin errors++; $display("FAIL reset_active_ch: got %0d expected 0", bus.active_ch); end
    checks++; if (bus.pending !== '0) begin errors++; $display("FAIL reset_pending: got %b expected 0", bus.pending); end
    checks++; if (bus.timeout_pulse !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b expected 0", bus.timeout_pulse); end
    checks++; if (bus.served_count !== '0) begin errors++; $display("FAIL reset_served: got %0d expected 0", bus.served_count); end
  endtask

  task automatic test_single_event();
    do_reset();
    tick(4'b0100, 1'b0);
    checks++; if (bus.pending !== 4'b0100) begin errors++; $display("FAIL single_pending: got %b expected 0100", bus.pending); end
    checks++; if (bus.robot_enabled !== 1'b0) begin errors++; $display("FAIL single_en_early: got %b expected 0", bus.robot_enabled); end
    tick('0, 1'b0);
    checks++; if (bus.robot_enabled !== 1'b1) begin errors++; $display("FAIL single_en: got %b expected 1", bus.robot_enabled); end
    checks++; if (bus.active_ch !== CH_W'(2)) begin errors++; $display("FAIL single_active_ch: got %0d expected 2", bus.active_ch); end
    checks++; if (bus.pending !== 4'b0000) begin errors++; $display("FAIL single_pending_clr: got %b expected 0000", bus.pending); end
    tick('0, 1'b1);
    checks++; if (bus.robot_enabled !== 1'b0) begin errors++; $display("FAIL single_en_fall: got %b expected 0", bus.robot_enabled); end
    checks++; if (bus.served_count !== CNT_W'(1)) begin errors++; $display("FAIL single_served: got %0d expected 1", bus.served_count); end
    idle_ticks(3);
  endtask

  task automatic test_round_robin();
    int order [6] = '{0, 1, 2, 3, 0, 3};
    int n;
    do_reset();
    tick(4'b1111, 1'b0);
    for (int g = 0; g < 6; g++) begin
      if (g == 4) begin
        idle_ticks(4);
        tick(4'b1001, 1'b0);
      end
      n = 0;
      while (bus.robot_enabled !== 1'b1 && n < 20) begin
        tick('0, 1'b0);
        n++;
      end
      checks++; if (n >= 20) begin errors++; $display("FAIL rr_wait_grant %0d: waited %0d cycles, limit 20", g, n); end
      checks++; if (bus.active_ch !== CH_W'(order[g])) begin errors++; $display("FAIL rr_order %0d: got %0d expected %0d", g, bus.active_ch, order[g]); end
      tick('0, 1'b1);
      if (g == 3) begin
        checks++; if (bus.served_count !== CNT_W'(CNT_MAX)) begin errors++; $display("FAIL rr_served: got %0d expected %0d", bus.served_count, CNT_MAX); end
      end
    end
    idle_ticks(3);
  endtask

  task automatic test_timeout();
    int hi, lo;
    do_reset();
    tick(4'b0010, 1'b0);
    tick('0, 1'b0);
    hi = 1;
    while (bus.robot_enabled === 1'b1 && hi < 20) begin
      tick('0, 1'b0);
      if (bus.robot_enabled === 1'b1) hi++;
    end
    checks++; if (hi != int'(TIMEOUT)) begin errors++; $display("FAIL to_high_cycles: got %0d expected %0d", hi, TIMEOUT); end
    checks++; if (bus.timeout_pulse !== 1'b1) begin errors++; $display("FAIL to_pulse: got %b expected 1", bus.timeout_pulse); end
    checks++; if (bus.pending !== 4'b0010) begin errors++; $display("FAIL to_requeue: got %b expected 0010", bus.pending); end
    checks++; if (bus.served_count !== '0) begin errors++; $display("FAIL to_served: got %0d expected 0", bus.served_count); end
    tick('0, 1'b0);
    checks++; if (bus.timeout_pulse !== 1'b0) begin errors++; $display("FAIL to_pulse_width: got %b expected 0", bus.timeout_pulse); end
    lo = 2;
    while (bus.robot_enabled !== 1'b1 && lo < 20) begin
      tick('0, 1'b0);
      if (bus.robot_enabled !== 1'b1) lo++;
    end
    checks++; if (lo != int'(COOLDOWN) + 1) begin errors++; $display("FAIL to_low_cycles: got %0d expected %0d", lo, COOLDOWN + 1); end
    checks++; if (bus.active_ch !== CH_W'(1)) begin errors++; $display("FAIL to_regrant: got %0d expected 1", bus.active_ch); end
    tick('0, 1'b1);
    idle_ticks(3);
  endtask

  task automatic test_collisions();
    int n;
    do_reset();
    tick(4'b0001, 1'b0);
    tick('0, 1'b0);
    repeat (TIMEOUT - 1) tick('0, 1'b0);
    checks++; if (bus.robot_enabled !== 1'b1) begin errors++; $display("FAIL col_en_last: got %b expected 1", bus.robot_enabled); end
    tick('0, 1'b1);
    checks++; if (bus.timeout_pulse !== 1'b0) begin errors++; $display("FAIL col_no_timeout: got %b expected 0", bus.timeout_pulse); end
    checks++; if (bus.served_count !== CNT_W'(1)) begin errors++; $display("FAIL col_served: got %0d expected 1", bus.served_count); end
    checks++; if (bus.pending !== 4'b0000) begin errors++; $display("FAIL col_no_requeue: got %b expected 0000", bus.pending); end
    idle_ticks(3);
    tick(4'b0100, 1'b0);
    tick(4'b0100, 1'b0);
    checks++; if (bus.robot_enabled !== 1'b1 || bus.active_ch !== CH_W'(2)) begin errors++; $display("FAIL col_grant: got en=%b ch=%0d expected en=1 ch=2", bus.robot_enabled, bus.active_ch); end
    checks++; if (bus.pending !== 4'b0100) begin errors++; $display("FAIL col_set_wins: got %b expected 0100", bus.pending); end
    tick('0, 1'b1);
    n = 0;
    while (bus.robot_enabled !== 1'b1 && n < 20) begin
      tick('0, 1'b0);
      n++;
    end
    checks++; if (n >= 20 || bus.active_ch !== CH_W'(2)) begin errors++; $display("FAIL col_regrant: got ch=%0d after %0d cycles expected ch=2", bus.active_ch, n); end
    tick('0, 1'b1);
    idle_ticks(3);
  endtask

  task automatic test_mid_reset();
    do_reset();
    tick(4'b0100, 1'b0);
    tick('0, 1'b0);
    tick('0, 1'b1);
    idle_ticks(3);
    tick(4'b0110, 1'b0);
    tick('0, 1'b0);
    checks++; if (bus.active_ch !== CH_W'(1)) begin errors++; $display("FAIL mr_grant: got %0d expected 1", bus.active_ch); end
    tick(4'b0010, 1'b0);
    checks++; if (bus.pending !== 4'b0110) begin errors++; $display("FAIL mr_pending_pre: got %b expected 0110", bus.pending); end
    reset = 1'b1;
    model_reset();
    #1;
    checks++; if (bus.robot_enabled !== 1'b0) begin errors++; $display("FAIL mr_en: got %b expected 0", bus.robot_enabled); end
    checks++; if (bus.pending !== '0) begin errors++; $display("FAIL mr_pending: got %b expected 0000", bus.pending); end
    checks++; if (bus.served_count !== '0) begin errors++; $display("FAIL mr_served: got %0d expected 0", bus.served_count); end
    @(posedge clk);
    #1;
    reset = 1'b0;
    tick(4'b1000, 1'b0);
    tick('0, 1'b0);
    checks++; if (bus.robot_enabled !== 1'b1 || bus.active_ch !== CH_W'(3)) begin errors++; $display("FAIL mr_after: got en=%b ch=%0d expected en=1 ch=3", bus.robot_enabled, bus.active_ch); end
    tick('0, 1'b1);
    idle_ticks(3);
    tick(4'b1001, 1'b0);
    tick('0, 1'b0);
    checks++; if (bus.active_ch !== CH_W'(0)) begin errors++; $display("FAIL mr_after_ch0: got %0d expected 0", bus.active_ch); end
    tick('0, 1'b1);
    idle_ticks(8);
  endtask

  task automatic test_saturation();
    int exp_cnt;
    do_reset();
    for (int k = 1; k <= 5; k++) begin
      tick(4'b0001, 1'b0);
      tick('0, 1'b0);
      tick('0, 1'b1);
      exp_cnt = (k < CNT_MAX) ? k : CNT_MAX;
      checks++; if (bus.served_count !== CNT_W'(exp_cnt)) begin errors++; $display("FAIL sat_served %0d: got %0d expected %0d", k, bus.served_count, exp_cnt); end
      idle_ticks(3);
    end
  endtask

  task automatic test_random();
    bit [NUM_CH-1:0] csl;
    bit res;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      csl = NUM_CH'($urandom) & NUM_CH'($urandom) & NUM_CH'($urandom);
      res = ($urandom_range(0, 7) == 0);
      tick(csl, res);
      checks++; if (bus.robot_enabled !== m_en) begin errors++; $display("FAIL rand_en @%0d: got %b expected %b", i, bus.robot_enabled, m_en); end
      checks++; if (bus.active_ch !== CH_W'(m_ch)) begin errors++; $display("FAIL rand_active_ch @%0d: got %0d expected %0d", i, bus.active_ch, m_ch); end
      checks++; if (bus.pending !== m_pend) begin errors++; $display("FAIL rand_pending @%0d: got %b expected %b", i, bus.pending, m_pend); end
      checks++; if (bus.timeout_pulse !== m_to) begin errors++; $display("FAIL rand_timeout @%0d: got %b expected %b", i, bus.timeout_pulse, m_to); end
      checks++; if (bus.served_count !== CNT_W'(m_served)) begin errors++; $display("FAIL rand_served @%0d: got %0d expected %0d", i, bus.served_count, m_served); end
    end
  endtask

  initial begin
    bus.csl_valid = '0;
    bus.resolved  = 1'b0;
    model_reset();
    test_reset();
    test_single_event();
    test_round_robin();
    test_timeout();
    test_collisions();
    test_mid_reset();
    test_saturation();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
